// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch program-counter sequencer: state encoding and
// default vector constants reused by fetch and CSR blocks.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VEC  = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC   = 32'h0000_0100;
    localparam int          DEF_INC        = 4;
    localparam int          DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC selection for the fetch sequencer: priority redirect/stall/increment
// select plus the redirect alignment check.
module pc_sequencer_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
    parameter int              INC        = DEF_INC,
    parameter int              ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  pc_state_t       state,
    input  logic [XLEN-1:0] pc,
    input  logic            halt_req,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misalign
);

    // A zero-width check yields an all-zero mask, so ALIGN_BITS=0 never traps.
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    logic            redirect;
    logic [XLEN-1:0] target;

    always_comb begin
        redirect = 1'b0;
        target   = branch_target;
        next_pc  = pc;
        misalign = 1'b0;
        if (state == ST_RUN && !halt_req) begin
            if (branch_taken) begin
                redirect = 1'b1;
                target   = branch_target;
            end else if (jump) begin
                redirect = 1'b1;
                target   = jump_target;
            end else if (!stall) begin
                next_pc = pc + XLEN'(INC);
            end
        end
        if (redirect) begin
            if ((target & ALIGN_MASK) != '0) begin
                next_pc  = TRAP_VEC;
                misalign = 1'b1;
            end else begin
                next_pc = target;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: BOOT/RUN/HALT control, PC register and
// misaligned-redirect trap capture.
// state   | meaning
// BOOT    | PC held at reset vector for one cycle, fetch not yet valid
// RUN     | live fetch: increment, redirect, stall or halt request
// HALT    | fetch stopped, PC frozen until resume
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(DEF_TRAP_VEC),
    parameter int              INC        = DEF_INC,
    parameter int              ALIGN_BITS = DEF_ALIGN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_Next,
    output logic            pc_valid,
    output logic            trap,
    output logic [XLEN-1:0] epc
);

    pc_state_t       state;
    logic [XLEN-1:0] mux_pc;
    logic            misalign;

    pc_sequencer_next_mux #(
        .XLEN       (XLEN),
        .TRAP_VEC   (TRAP_VEC),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_mux (
        .state         (state),
        .pc            (PC),
        .halt_req      (halt_req),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_pc       (mux_pc),
        .misalign      (misalign)
    );

    assign PC_Next = rst ? mux_pc : RESET_VEC;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_BOOT;
            PC       <= RESET_VEC;
            pc_valid <= 1'b0;
            trap     <= 1'b0;
            epc      <= '0;
        end else begin
            PC   <= mux_pc;
            trap <= misalign;
            if (misalign) begin
                epc <= PC;
            end
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state    <= ST_HALT;
                        pc_valid <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // resume has priority over a simultaneous halt_req
                    if (resume) begin
                        state    <= ST_RUN;
                        pc_valid <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed stimulus with hand-computed expectations pushed into a scoreboard queue;
// a monitor process pops and compares the DUT outputs every cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_req, resume, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] PC, PC_Next, epc;
    logic        pc_valid, trap;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        trap;
        logic [31:0] epc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .halt_req      (halt_req),
        .resume        (resume),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .PC            (PC),
        .PC_Next       (PC_Next),
        .pc_valid      (pc_valid),
        .trap          (trap),
        .epc           (epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge and queue the state expected after the next posedge.
    task automatic cyc(input logic r, input logic hr, input logic res, input logic st,
                       input logic bt, input logic [31:0] btg, input logic j,
                       input logic [31:0] jt, input logic [31:0] e_pc, input logic e_v,
                       input logic e_t, input logic [31:0] e_epc);
        exp_t e;
        @(negedge clk);
        rst = r; halt_req = hr; resume = res; stall = st;
        branch_taken = bt; branch_target = btg; jump = j; jump_target = jt;
        e.pc = e_pc; e.valid = e_v; e.trap = e_t; e.epc = e_epc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_epc);
        cyc(1, 0, 0, 0, 0, 32'h0, 0, 32'h0, e_pc, e_v, 0, e_epc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) check("pc_next", PC_Next, exp_q[0].pc);
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", PC, e.pc);
                check("pc_valid", {31'b0, pc_valid}, {31'b0, e.valid});
                check("trap", {31'b0, trap}, {31'b0, e.trap});
                check("epc", epc, e.epc);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 0; halt_req = 0; resume = 0; stall = 0;
        branch_taken = 0; branch_target = 0; jump = 0; jump_target = 0;

        // reset, boot, sequential increment
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        idle(32'h0, 1, 32'h0);
        idle(32'h4, 1, 32'h0);
        idle(32'h8, 1, 32'h0);
        idle(32'hC, 1, 32'h0);
        idle(32'h10, 1, 32'h0);

        // stall holds, redirect overrides stall
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 32'h10, 1, 0, 32'h0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 32'h10, 1, 0, 32'h0);
        cyc(1, 0, 0, 1, 1, 32'h40, 0, 0, 32'h40, 1, 0, 32'h0);

        // branch beats jump, then jump alone
        cyc(1, 0, 0, 0, 1, 32'h80, 1, 32'h200, 32'h80, 1, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 1, 32'h200, 32'h200, 1, 0, 32'h0);

        // misaligned jump and branch trap to 0x100
        cyc(1, 0, 0, 0, 0, 0, 1, 32'h20, 32'h20, 1, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 1, 32'h202, 32'h100, 1, 1, 32'h20);
        idle(32'h104, 1, 32'h20);
        idle(32'h108, 1, 32'h20);
        cyc(1, 0, 0, 0, 1, 32'h41, 0, 0, 32'h100, 1, 1, 32'h108);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 32'h100, 1, 0, 32'h108);

        // halt ignores redirects, resume wins over halt_req
        cyc(1, 0, 0, 0, 0, 0, 1, 32'h30, 32'h30, 1, 0, 32'h108);
        cyc(1, 1, 0, 0, 1, 32'h80, 0, 0, 32'h30, 0, 0, 32'h108);
        cyc(1, 0, 0, 0, 1, 32'h80, 0, 0, 32'h30, 0, 0, 32'h108);
        cyc(1, 0, 0, 1, 0, 0, 1, 32'h42, 32'h30, 0, 0, 32'h108);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 32'h30, 1, 0, 32'h108);
        idle(32'h34, 1, 32'h108);

        // wrap-around, then reset from HALT
        cyc(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 32'h108);
        idle(32'h0, 1, 32'h108);
        idle(32'h4, 1, 32'h108);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 32'h108);
        cyc(0, 0, 1, 0, 1, 32'h80, 0, 0, 32'h0, 0, 0, 32'h0);
        idle(32'h0, 1, 32'h0);
        idle(32'h4, 1, 32'h0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
